data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Memory-side end of the core's SRAM-like data port; responds to the en/wen/addr/wdata requests the
//  core drives each cycle. Holds a byte-writable word RAM and a free-running timer register (MMIO).
//  Returns read data after a fixed, parameterised latency. Used as data memory in sim and FPGA builds.
//  Addresses arrive physical (kseg0/1 already stripped); wdata arrives lane-shifted per addr[1:0].
// PARAMETERS
//  ADDR_W        14            word-address width; RAM = 2**ADDR_W words (64 KiB default)
//  READ_LATENCY  1             cycles from request to data_sram_rdata; legal 1..4
//  MEM_BASE      32'h0000_0000 physical base of RAM window
//  TIMER_ADDR    32'h1faf_e000 physical word address of timer register
// PORTS
//  clk                 in   1   single clock, all state on rising edge
//  reset               in   1   synchronous, active-high
//  data_sram_en        in   1   request valid this cycle
//  data_sram_wen       in   4   byte-lane write enables; 4'b0000 with en = read
//  data_sram_addr      in   32  physical byte address
//  data_sram_wdata     in   32  lane-aligned store data (lane i = wdata[8i+7:8i])
//  data_sram_rdata     out  32  read data, READ_LATENCY cycles after request
//  data_sram_rvalid    out  1   high in the cycle rdata carries a read response
//  data_sram_err       out  1   high with rvalid if read address decoded to nothing
// BEHAVIOUR
//  - Reset: rdata=0, rvalid=0, err=0, timer=0, latency pipeline flushed. RAM contents are not reset.
//  - Reset asserted mid-operation: in-flight reads are dropped (no rvalid); writes issued in a reset cycle are ignored.
//  - Decode: RAM hit if addr in [MEM_BASE, MEM_BASE+4*2**ADDR_W); index = (addr-MEM_BASE)[ADDR_W+1:2].
//    Timer hit if addr[31:2]==TIMER_ADDR[31:2]. Else miss. addr[1:0] is ignored for decode.
//  - Write (en & |wen): each lane i with wen[i] updates byte i of the addressed word at the clock edge.
//    Timer write: lanes update timer bytes; on that edge write wins over increment.
//    Miss write: silently dropped, no err (err is read-only signalling).
//  - Read (en & wen==0): word captured at request edge into stage 0 of a READ_LATENCY-deep shift pipe
//    of {valid, err, data}; last stage drives rvalid/err/rdata. Full 32-bit word is returned, no
//    lane shifting or sign extension (the core aligns loads). Miss read: data 0, err=1.
//  - Back-to-back reads are accepted every cycle; one response per request, in order, no stall.
//  - Read and write never share a request (wen selects). A read immediately after a write to the
//    same word sees the new data. A read of the timer returns its pre-increment value of that edge.
//  - Timer: 32-bit, +1 every cycle when not in reset and not being written; wraps 0xffff_ffff -> 0.
//  - en=0: no state change except timer; pipe shifts in an invalid entry. rdata holds its last value
//    when rvalid=0.
//  - Widths: index arithmetic in 32 bits, truncated to ADDR_W; no carry outside the window.
// STRUCTURE
//  - Shared package (dm_pkg): MEM_BASE/TIMER_ADDR defaults, lane-count constant 4, decode-result
//    enum {DEC_RAM, DEC_TIMER, DEC_MISS}.
//  - One sub-module: dm_byte_ram (2**ADDR_W x 32, 4 byte-enables, synchronous read, read-first);
//    top holds decode, timer and latency pipe.
// TESTING
//  1 Reset then read addr 0x0 (RAM prefilled 0x11223344), LAT=1 -> next cycle rvalid=1, rdata=0x11223344, err=0.
//  2 Write wen=4'b0100 addr 0x12 wdata 0x00AB_0000 onto 0xFFFF_FFFF, then read 0x10 -> rdata 0xFFAB_FFFF.
//  3 LAT=3, reads to 0x0,0x4,0x8 on consecutive cycles -> three rvalid pulses on cycles 3,4,5, in order.
//  4 Read 0x8000_0000 (miss) -> rvalid=1, err=1, rdata=0; write to same address changes no RAM word.
//  5 Write timer 0xFFFF_FFFE, read twice back-to-back -> 0xFFFF_FFFF, 0x0000_0000 (wrap).
//  6 Issue read, assert reset the next cycle with LAT=2 -> rvalid never pulses; rdata=0 after reset.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants, decode result type and address decoder for the data SRAM responder.
package dm_pkg;

  localparam int          LANES          = 4;
  localparam logic [31:0] MEM_BASE_DEF   = 32'h0000_0000;
  localparam logic [31:0] TIMER_ADDR_DEF = 32'h1faf_e000;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_TIMER,
    DEC_MISS
  } dec_e;

  // Byte offset low bits are irrelevant: both windows are word granular.
  function automatic dec_e dm_decode(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] timer,
    input int          addr_w
  );
    logic [31:0] off;
    logic [32:0] span;
    logic        ram_hit;
    off     = addr - base;
    span    = 33'd4 << addr_w;
    ram_hit = (addr >= base) && ({1'b0, off} < span);
    if (addr[31:2] == timer[31:2]) begin
      return DEC_TIMER;
    end else if (ram_hit) begin
      return DEC_RAM;
    end
    return DEC_MISS;
  endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Word RAM with per-byte write enables and a registered, read-first read port.
module dm_byte_ram import dm_pkg::*; #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              re,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane keeps each lane a plain block RAM.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
      if (re) begin
        rdata_q <= mem[addr];
      end
      if (we[gi]) begin
        mem[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = rdata_q;
  end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the core data port: byte-writable RAM, MMIO timer, fixed-latency reads.
module data_sram_responder import dm_pkg::*; #(
  parameter int          ADDR_W       = 14,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MEM_BASE     = MEM_BASE_DEF,
  parameter logic [31:0] TIMER_ADDR   = TIMER_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        data_sram_err
);

  dec_e              dec;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] ram_idx;
  logic              is_read;
  logic              is_write;
  logic [LANES-1:0]  ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;

  logic [31:0] timer_q, timer_d;
  logic        s0_valid_q, s0_valid_d;
  logic        s0_err_q, s0_err_d;
  logic        s0_ram_q, s0_ram_d;
  logic [31:0] s0_data_q, s0_data_d;
  logic [31:0] hold_q, hold_d;

  logic [READ_LATENCY-1:0]       pipe_valid;
  logic [READ_LATENCY-1:0]       pipe_err;
  logic [READ_LATENCY-1:0][31:0] pipe_data;

  assign dec      = dm_decode(data_sram_addr, MEM_BASE, TIMER_ADDR, ADDR_W);
  assign offset   = data_sram_addr - MEM_BASE;
  assign ram_idx  = ADDR_W'(offset >> 2);
  // Requests seen during reset are discarded outright.
  assign is_read  = data_sram_en && (data_sram_wen == 4'b0000) && !reset;
  assign is_write = data_sram_en && (data_sram_wen != 4'b0000) && !reset;
  assign ram_we   = (is_write && dec == DEC_RAM) ? data_sram_wen : '0;
  assign ram_re   = is_read && dec == DEC_RAM;

  dm_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (ram_idx),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (is_write && dec == DEC_TIMER) begin
      timer_d = timer_q;
      for (int i = 0; i < LANES; i++) begin
        if (data_sram_wen[i]) begin
          timer_d[8*i +: 8] = data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage 0 defers the RAM word to the RAM's own output register; timer/miss data is captured here.
  always_comb begin
    s0_valid_d = is_read;
    s0_err_d   = is_read && (dec == DEC_MISS);
    s0_ram_d   = is_read && (dec == DEC_RAM);
    s0_data_d  = (is_read && dec == DEC_TIMER) ? timer_q : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      s0_valid_q <= 1'b0;
      s0_err_q   <= 1'b0;
      s0_ram_q   <= 1'b0;
      s0_data_q  <= '0;
      hold_q     <= '0;
    end else begin
      timer_q    <= timer_d;
      s0_valid_q <= s0_valid_d;
      s0_err_q   <= s0_err_d;
      s0_ram_q   <= s0_ram_d;
      s0_data_q  <= s0_data_d;
      hold_q     <= hold_d;
    end
  end

  assign pipe_valid[0] = s0_valid_q;
  assign pipe_err[0]   = s0_err_q;
  assign pipe_data[0]  = s0_ram_q ? ram_rdata : s0_data_q;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    always_comb begin
      valid_d = pipe_valid[gi-1];
      err_d   = pipe_err[gi-1];
      data_d  = pipe_data[gi-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        data_q  <= data_d;
      end
    end

    assign pipe_valid[gi] = valid_q;
    assign pipe_err[gi]   = err_q;
    assign pipe_data[gi]  = data_q;
  end

  // Output data is held between responses so the bus stays stable while rvalid is low.
  assign data_sram_rvalid = pipe_valid[READ_LATENCY-1];
  assign data_sram_err    = pipe_valid[READ_LATENCY-1] & pipe_err[READ_LATENCY-1];
  assign data_sram_rdata  = pipe_valid[READ_LATENCY-1] ? pipe_data[READ_LATENCY-1] : hold_q;

  always_comb begin
    hold_d = data_sram_rdata;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench: three responders (latency 1..3) share stimulus and are checked against a word-level model.
module tb_data_sram_responder;

  localparam int          NLAT    = 3;
  localparam int          MAXC    = 4096;
  localparam int          NPOOL   = 12;
  localparam int          NMISS   = 5;
  localparam logic [31:0] TIMER_A = 32'h1faf_e000;
  localparam logic [31:0] RAM_END = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata  [NLAT];
  logic        rvalid [NLAT];
  logic        err    [NLAT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NLAT; gi++) begin : g_dut
    data_sram_responder #(
      .READ_LATENCY(gi + 1)
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .data_sram_en    (en),
      .data_sram_wen   (wen),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata[gi]),
      .data_sram_rvalid(rvalid[gi]),
      .data_sram_err   (err[gi])
    );
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Per-cycle history of requests: reset flag and the response each read deserves.
  bit          rs_a [MAXC];
  bit          rv_a [MAXC];
  bit          re_a [MAXC];
  logic [31:0] rd_a [MAXC];

  logic [31:0] mem_m [int];
  logic [31:0] timer_m;
  logic [31:0] hold_m [NLAT];
  logic [31:0] pool   [NPOOL];
  logic [31:0] misses [NMISS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_cycle(input logic rst, input logic e, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d);
    logic        hit_ram;
    logic        hit_tmr;
    logic [31:0] old;
    int          widx;
    reset = rst;
    en    = e;
    wen   = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    for (int l = 0; l < NLAT; l++) begin
      int          c;
      bit          ok;
      bit          exp_err;
      logic [31:0] exp_d;
      c  = cyc - (l + 1);
      ok = (c >= 0) && rv_a[c];
      for (int k = (c < 0 ? 0 : c); k < cyc; k++) begin
        if (rs_a[k]) ok = 1'b0;
      end
      exp_d   = ok ? rd_a[c] : hold_m[l];
      exp_err = ok ? re_a[c] : 1'b0;
      check($sformatf("rvalid_L%0d", l + 1), 32'(rvalid[l]), 32'(ok));
      check($sformatf("err_L%0d", l + 1), 32'(err[l]), 32'(exp_err));
      check($sformatf("rdata_L%0d", l + 1), rdata[l], exp_d);
      hold_m[l] = rst ? 32'd0 : exp_d;
    end

    hit_tmr  = (a[31:2] == TIMER_A[31:2]);
    hit_ram  = (a < RAM_END);
    widx     = int'(a >> 2);
    rs_a[cyc] = rst;
    rv_a[cyc] = 1'b0;
    re_a[cyc] = 1'b0;
    rd_a[cyc] = 32'd0;
    if (!rst && e && w == 4'b0000) begin
      rv_a[cyc] = 1'b1;
      if (hit_tmr) rd_a[cyc] = timer_m;
      else if (hit_ram) rd_a[cyc] = mem_m.exists(widx) ? mem_m[widx] : 32'd0;
      else re_a[cyc] = 1'b1;
    end
    if (rst || e) begin
      $display("txn cyc=%0d rst=%0b en=%0b wen=%h addr=%h wdata=%h", cyc, rst, e, w, a, d);
    end

    if (rst) begin
      timer_m = 32'd0;
    end else begin
      if (e && w != 4'b0000 && hit_tmr) begin
        for (int i = 0; i < 4; i++) if (w[i]) timer_m[8*i +: 8] = d[8*i +: 8];
      end else begin
        if (e && w != 4'b0000 && hit_ram) begin
          old = mem_m.exists(widx) ? mem_m[widx] : 32'd0;
          for (int i = 0; i < 4; i++) if (w[i]) old[8*i +: 8] = d[8*i +: 8];
          mem_m[widx] = old;
        end
        timer_m = timer_m + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    pool   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h2000, 32'h8000,
               32'hFFF0, 32'hFFF4, 32'hFFF8, 32'hFFFC};
    misses = '{32'h0001_0000, 32'h8000_0000, 32'h1faf_dffc, 32'h1faf_e004, 32'hFFFF_FFFC};
    for (int l = 0; l < NLAT; l++) hold_m[l] = 32'd0;
    timer_m = 32'd0;

    reset = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    @(posedge clk);
    #1;

    // Prefill every pool word with a full write so all later reads are defined.
    for (int i = 0; i < NPOOL; i++) do_cycle(1'b0, 1'b1, 4'hF, pool[i], $urandom);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h0, 32'h1122_3344);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);

    // RAM survives reset; first read after reset.
    do_cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    // Single-lane write then immediate read of the same word.
    do_cycle(1'b0, 1'b1, 4'b0100, 32'h12, 32'h00AB_0000);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    // Back-to-back reads.
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h8, 32'h0);
    // Misses: reads flag err, writes just past the window must not alias into RAM.
    do_cycle(1'b0, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'hFFFC, 32'h0);
    // Timer wrap.
    do_cycle(1'b0, 1'b1, 4'hF, TIMER_A, 32'hFFFF_FFFE);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, TIMER_A, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, TIMER_A, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, TIMER_A, 32'h0);
    // Reset right behind a read drops it.
    do_cycle(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
    do_cycle(1'b1, 1'b1, 4'hF, 32'h4, 32'h5555_AAAA);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b0, 1'b1, 4'h0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] pa;
      logic [31:0] ma;
      r  = $urandom_range(0, 39);
      pa = pool[$urandom_range(0, NPOOL - 1)] | 32'($urandom_range(0, 3));
      ma = misses[$urandom_range(0, NMISS - 1)];
      if (r < 16)       do_cycle(1'b0, 1'b1, 4'h0, pa, 32'h0);
      else if (r < 26)  do_cycle(1'b0, 1'b1, 4'($urandom_range(1, 15)), pa, $urandom);
      else if (r < 30)  do_cycle(1'b0, 1'b1, 4'h0, TIMER_A | 32'($urandom_range(0, 3)), 32'h0);
      else if (r < 31)  do_cycle(1'b0, 1'b1, 4'($urandom_range(1, 15)), TIMER_A, $urandom);
      else if (r < 34)  do_cycle(1'b0, 1'b1, 4'h0, ma, 32'h0);
      else if (r < 36)  do_cycle(1'b0, 1'b1, 4'($urandom_range(1, 15)), ma, $urandom);
      else if (r < 39)  do_cycle(1'b0, 1'b0, 4'h0, pa, $urandom);
      else              do_cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pa, $urandom);
    end
    // Sweep the pool so any corruption from miss writes is observed.
    for (int i = 0; i < NPOOL; i++) do_cycle(1'b0, 1'b1, 4'h0, pool[i], 32'h0);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
